seq_pattern_det: RTL

- Parametrised serial bit-pattern detector; successor to the fixed-sequence detector FSMs.
- Accepts a qualified serial bit stream and matches it against a runtime-loaded pattern of length 1..PAT_W.
- Supports overlap, sticky-lock and anchored modes, with a saturating match counter.
- Sits between a serial input front-end and control logic that needs match, lock or fail indication.

---
 rtl/seq_pattern_det_pkg.sv | 15 +
 rtl/sat_counter.sv | 38 +++
 rtl/seq_pattern_det.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_det_pkg.sv
// Shared types and defaults for the serial bit-pattern detector.
// State encodings are kept as plain localparams for compatibility with older detector code.
package seq_pattern_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_HUNT = 2'b01;
  localparam state_t ST_LOCK = 2'b10;
  localparam state_t ST_FAIL = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear combined with an increment yields one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear has priority, increment stops at all ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_pattern_det.sv
// Parametrised serial pattern detector with overlap, sticky-lock and anchored modes.
// Build option SEQ_PATTERN_DET_COUNT_EN adds the saturating match counter.
module seq_pattern_det
  import seq_pattern_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_arm,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cfg_sticky,
  input  logic             cfg_anchored,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             match,
  output logic             locked,
  output logic             failed,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_count
);

  state_t           state_q,   state_d;
  logic [PAT_W-1:0] hist_q,    hist_d;
  logic [LEN_W-1:0] fill_q,    fill_d;
  logic [PAT_W-1:0] pat_q,     pat_d;
  logic [LEN_W-1:0] len_q,     len_d;
  logic             ovl_q,     ovl_d;
  logic             sticky_q,  sticky_d;
  logic             anch_q,    anch_d;
  logic             match_q,   match_d;
  logic             cfg_err_q, cfg_err_d;

  logic [PAT_W-1:0] hist_sh_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] exp_idx_s;
  logic [PAT_W-1:0] exp_vec_s;
  logic             hit_s;
  logic             anch_bad_s;
  logic             len_ok_s;

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(l));
    end
    return m;
  endfunction

  // datapath terms for the bit currently offered on the serial input
  always_comb begin
    hist_sh_s  = {hist_q[PAT_W-2:0], in_bit};
    fill_inc_s = (fill_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : (fill_q + LEN_W'(1));
    mask_s     = len_mask(len_q);
    hit_s      = (fill_inc_s >= len_q) && ((hist_sh_s & mask_s) == (pat_q & mask_s));
    // expected anchored bit is pattern[len-1-fill], only meaningful while fill < len
    exp_idx_s  = len_q - fill_q - LEN_W'(1);
    exp_vec_s  = pat_q >> exp_idx_s;
    anch_bad_s = anch_q && (fill_q < len_q) && (in_bit != exp_vec_s[0]);
    len_ok_s   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  end

  // next-state: arm has priority over any serial bit in the same cycle
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    sticky_d  = sticky_q;
    anch_d    = anch_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    if (cfg_arm) begin
      if (len_ok_s) begin
        pat_d    = cfg_pattern;
        len_d    = cfg_len;
        ovl_d    = cfg_overlap;
        sticky_d = cfg_sticky;
        anch_d   = cfg_anchored;
        hist_d   = '0;
        fill_d   = '0;
        state_d  = ST_HUNT;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_HUNT: begin
          if (!in_valid) begin
            state_d = ST_HUNT;
          end else if (anch_bad_s) begin
            state_d = ST_FAIL;
          end else begin
            hist_d = hist_sh_s;
            fill_d = fill_inc_s;
            if (hit_s) begin
              match_d = 1'b1;
              if (sticky_q) begin
                state_d = ST_LOCK;
              end else if (anch_q || !ovl_q) begin
                fill_d = '0;
              end else begin
                fill_d = fill_inc_s;
              end
            end else begin
              match_d = 1'b0;
            end
          end
        end
        ST_LOCK: state_d = ST_LOCK;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state, history and configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      sticky_q  <= 1'b0;
      anch_q    <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      sticky_q  <= sticky_d;
      anch_q    <= anch_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign armed   = (state_q == ST_HUNT);
  assign locked  = (state_q == ST_LOCK);
  assign failed  = (state_q == ST_FAIL);
  assign match   = match_q;
  assign cfg_err = cfg_err_q;

  // the oldest history bit is shifted out before it is ever compared
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_W-1];

`ifdef SEQ_PATTERN_DET_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (match_q),
    .clr_i (cnt_clr),
    .cnt_o (match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule
